// File: rtl/knight_pkg.sv
// Shared constants and types for the knight's-tour command replay block.
// Move-bit indices, headings, opcodes, response bytes and the replay state type.
package knight_pkg;

    localparam int DEF_NUM_MOVES = 24;

    // Bit positions inside the one-hot move byte, named (vertical leg, horizontal leg)
    localparam int MV_N2_E1 = 0;
    localparam int MV_N2_W1 = 1;
    localparam int MV_N1_W2 = 2;
    localparam int MV_S1_W2 = 3;
    localparam int MV_S2_W1 = 4;
    localparam int MV_S2_E1 = 5;
    localparam int MV_S1_E2 = 6;
    localparam int MV_N1_E2 = 7;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [3:0] OP_MOVE         = 4'b0010;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;

    localparam logic [7:0] RESP_TOUR = 8'h5A;
    localparam logic [7:0] RESP_IDLE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VERT  = 3'd1,
        ST_HOLDV = 3'd2,
        ST_HORZ  = 3'd3,
        ST_HOLDH = 3'd4
    } replay_state_t;

    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] head,
                                             input logic [3:0] cnt);
        return {op, head, cnt};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into vertical and horizontal legs.
// Lowest set bit wins; an all-zero move yields two zero-length north legs.
module tour_move_decode
    import knight_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] vert_head,
    output logic [3:0] vert_cnt,
    output logic [7:0] horz_head,
    output logic [3:0] horz_cnt
);

    // Priority decode of the move byte into two legs
    always_comb begin
        vert_head = HEAD_N;
        vert_cnt  = 4'd0;
        horz_head = HEAD_N;
        horz_cnt  = 4'd0;
        if (move[MV_N2_E1]) begin
            vert_head = HEAD_N; vert_cnt = 4'd2;
            horz_head = HEAD_E; horz_cnt = 4'd1;
        end else if (move[MV_N2_W1]) begin
            vert_head = HEAD_N; vert_cnt = 4'd2;
            horz_head = HEAD_W; horz_cnt = 4'd1;
        end else if (move[MV_N1_W2]) begin
            vert_head = HEAD_N; vert_cnt = 4'd1;
            horz_head = HEAD_W; horz_cnt = 4'd2;
        end else if (move[MV_S1_W2]) begin
            vert_head = HEAD_S; vert_cnt = 4'd1;
            horz_head = HEAD_W; horz_cnt = 4'd2;
        end else if (move[MV_S2_W1]) begin
            vert_head = HEAD_S; vert_cnt = 4'd2;
            horz_head = HEAD_W; horz_cnt = 4'd1;
        end else if (move[MV_S2_E1]) begin
            vert_head = HEAD_S; vert_cnt = 4'd2;
            horz_head = HEAD_E; horz_cnt = 4'd1;
        end else if (move[MV_S1_E2]) begin
            vert_head = HEAD_S; vert_cnt = 4'd1;
            horz_head = HEAD_E; horz_cnt = 4'd2;
        end else if (move[MV_N1_E2]) begin
            vert_head = HEAD_N; vert_cnt = 4'd1;
            horz_head = HEAD_E; horz_cnt = 4'd2;
        end else begin
            vert_head = HEAD_N; vert_cnt = 4'd0;
            horz_head = HEAD_N; horz_cnt = 4'd0;
        end
    end

endmodule

// File: rtl/tour_cmd_replay.sv
// Replays a solved knight's tour as vertical/horizontal move commands, else forwards UART.
// Optional build macro TOUR_FANFARE_EN: horizontal legs use the fanfare opcode.
module tour_cmd_replay
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = DEF_NUM_MOVES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HORZ_OP = OP_MOVE_FANFARE;
`else
    localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

    replay_state_t state_r;
    replay_state_t state_nxt_s;
    logic [4:0]    mv_indx_r;
    logic [4:0]    mv_indx_nxt_s;

    logic [7:0]    vert_head_s;
    logic [3:0]    vert_cnt_s;
    logic [7:0]    horz_head_s;
    logic [3:0]    horz_cnt_s;
    logic [15:0]   vert_cmd_s;
    logic [15:0]   horz_cmd_s;

    tour_move_decode u_decode (
        .move      (move),
        .vert_head (vert_head_s),
        .vert_cnt  (vert_cnt_s),
        .horz_head (horz_head_s),
        .horz_cnt  (horz_cnt_s)
    );

    assign vert_cmd_s = make_cmd(OP_MOVE, vert_head_s, vert_cnt_s);
    assign horz_cmd_s = make_cmd(HORZ_OP, horz_head_s, horz_cnt_s);
    assign mv_indx    = mv_indx_r;

    // Next-state and move-index logic; holds only advance on send_resp, issues only on clr_cmd_rdy
    always_comb begin
        state_nxt_s   = state_r;
        mv_indx_nxt_s = mv_indx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_tour) begin
                    state_nxt_s   = ST_VERT;
                    mv_indx_nxt_s = 5'd0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_VERT: begin
                if (clr_cmd_rdy) begin
                    state_nxt_s = ST_HOLDV;
                end else begin
                    state_nxt_s = ST_VERT;
                end
            end
            ST_HOLDV: begin
                if (send_resp) begin
                    state_nxt_s = ST_HORZ;
                end else begin
                    state_nxt_s = ST_HOLDV;
                end
            end
            ST_HORZ: begin
                if (clr_cmd_rdy) begin
                    state_nxt_s = ST_HOLDH;
                end else begin
                    state_nxt_s = ST_HORZ;
                end
            end
            ST_HOLDH: begin
                if (send_resp) begin
                    if (mv_indx_r == LAST_IDX) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s   = ST_VERT;
                        mv_indx_nxt_s = mv_indx_r + 5'd1;
                    end
                end else begin
                    state_nxt_s = ST_HOLDH;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                mv_indx_nxt_s = 5'd0;
            end
        endcase
    end

    // State and move-index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mv_indx_r <= 5'd0;
        end else begin
            state_r   <= state_nxt_s;
            mv_indx_r <= mv_indx_nxt_s;
        end
    end

    // Output mux: UART passthrough in IDLE, tour legs otherwise (UART stalled)
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_IDLE;
        case (state_r)
            ST_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_IDLE;
            end
            ST_VERT: begin
                cmd              = vert_cmd_s;
                cmd_rdy          = 1'b1;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_TOUR;
            end
            ST_HOLDV: begin
                cmd              = vert_cmd_s;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_TOUR;
            end
            ST_HORZ: begin
                cmd              = horz_cmd_s;
                cmd_rdy          = 1'b1;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_TOUR;
            end
            ST_HOLDH: begin
                cmd              = horz_cmd_s;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_TOUR;
            end
            default: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_replay.sv
// Scoreboard bench for tour_cmd_replay: expected legs queued at tour start, checked as issued.
module tb_tour_cmd_replay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic [7:0]  mem [0:23];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    bit          abort = 1'b0;

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HOP = 4'h3;
`else
    localparam logic [3:0] HOP = 4'h2;
`endif

    logic [7:0] vh_tab [0:7] = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00};
    logic [3:0] vc_tab [0:7] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1};
    logic [7:0] hh_tab [0:7] = '{8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hBF, 8'hBF, 8'hBF};
    logic [3:0] hc_tab [0:7] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2};

    assign move = mem[mv_indx];

    always #5 clk = ~clk;

    tour_cmd_replay dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horz);
        int b;
        b = -1;
        for (int i = 7; i >= 0; i--) if (m[i]) b = i;
        if (b < 0) return {(horz ? HOP : 4'h2), 8'h00, 4'h0};
        if (horz) return {HOP, hh_tab[b], hc_tab[b]};
        return {4'h2, vh_tab[b], vc_tab[b]};
    endfunction

    task automatic start_and_expect();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(exp_leg(mem[i], 1'b0));
            exp_q.push_back(exp_leg(mem[i], 1'b1));
        end
        issued = 0;
        @(negedge clk); start_tour = 1'b1;
        @(negedge clk); start_tour = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_resp();
        send_resp = 1'b1; @(negedge clk); send_resp = 1'b0;
    endtask

    // Handshake responder for n commands; noise drives inputs that must be ignored mid-tour
    task automatic serve_cmds(input int n, input bit noise);
        int cyc, d;
        logic [15:0] expv, held;
        for (int k = 0; k < n && !abort; k++) begin
            cyc = 0;
            while (cmd_rdy !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
            checks++;
            if (cmd_rdy !== 1'b1) begin
                $display("FAIL cmd_timeout: cmd_rdy=%b after %0d cycles, required 1", cmd_rdy, cyc);
                errors++; abort = 1'b1;
            end else begin
                expv = exp_q.pop_front();
                checks++;
                if (cmd !== expv) begin
                    $display("FAIL tour_cmd[%0d]: got %h, expected %h", issued, cmd, expv); errors++;
                end
                checks++;
                if (mv_indx !== 5'(issued / 2)) begin
                    $display("FAIL mv_indx[%0d]: got %0d, expected %0d", issued, mv_indx, issued / 2); errors++;
                end
                checks++;
                if (resp !== 8'h5A) begin
                    $display("FAIL resp_tour: got %h, expected 5a", resp); errors++;
                end
                held = cmd;
                d = $urandom_range(0, 9);
                repeat (d) begin
                    if (noise) begin send_resp = 1'b1; start_tour = 1'b1; cmd_rdy_UART = 1'b1; end
                    @(negedge clk);
                    send_resp = 1'b0; start_tour = 1'b0; cmd_rdy_UART = 1'b0;
                    checks++;
                    if (cmd_rdy !== 1'b1 || cmd !== held) begin
                        $display("FAIL cmd_stable: rdy=%b cmd=%h, expected rdy=1 cmd=%h", cmd_rdy, cmd, held); errors++;
                    end
                end
                clr_cmd_rdy = 1'b1; send_resp = noise;
                #1;
                checks++;
                if (clr_cmd_rdy_UART !== 1'b0) begin
                    $display("FAIL uart_stall: clr_cmd_rdy_UART=%b, expected 0", clr_cmd_rdy_UART); errors++;
                end
                @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b0;
                checks++;
                if (cmd_rdy !== 1'b0) begin
                    $display("FAIL hold_rdy: cmd_rdy=%b, expected 0", cmd_rdy); errors++;
                end
                issued++;
                d = $urandom_range(0, 9);
                repeat (d) begin
                    if (noise) begin clr_cmd_rdy = 1'b1; start_tour = 1'b1; cmd_rdy_UART = 1'b1; end
                    #1;
                    if (noise) begin
                        checks++;
                        if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0) begin
                            $display("FAIL hold_noise: clr_uart=%b rdy=%b, expected 0 0", clr_cmd_rdy_UART, cmd_rdy); errors++;
                        end
                    end
                    @(negedge clk);
                    clr_cmd_rdy = 1'b0; start_tour = 1'b0; cmd_rdy_UART = 1'b0;
                end
                pulse_resp();
            end
        end
    endtask

    task automatic end_of_tour(input string tag);
        checks++;
        if (issued !== 48 || exp_q.size() !== 0) begin
            $display("FAIL %s_count: issued=%0d left=%0d, expected 48 0", tag, issued, exp_q.size()); errors++;
        end
        checks++;
        if (mv_indx !== 5'd23 || resp !== 8'hA5) begin
            $display("FAIL %s_end: mv_indx=%0d resp=%h, expected 23 a5", tag, mv_indx, resp); errors++;
        end
        repeat (3) @(negedge clk);
        cmd_rdy_UART = 1'b1; cmd_UART = 16'h2155;
        #1;
        checks++;
        if (mv_indx !== 5'd23 || cmd_rdy !== 1'b1 || cmd !== 16'h2155) begin
            $display("FAIL %s_idle: mv_indx=%0d rdy=%b cmd=%h, expected 23 1 2155", tag, mv_indx, cmd_rdy, cmd); errors++;
        end
        @(negedge clk); cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd_rdy !== 1'b0) begin
            $display("FAIL reset: mv_indx=%0d resp=%h rdy=%b, expected 0 a5 0", mv_indx, resp, cmd_rdy); errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        #1;
        checks++;
        if (cmd !== 16'h2003 || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5) begin
            $display("FAIL passthrough: cmd=%h rdy=%b clr=%b resp=%h, expected 2003 1 1 a5",
                     cmd, cmd_rdy, clr_cmd_rdy_UART, resp); errors++;
        end
        @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        #1;
        checks++;
        if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0) begin
            $display("FAIL passthrough_off: clr=%b rdy=%b, expected 0 0", clr_cmd_rdy_UART, cmd_rdy); errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_single_move();
        for (int i = 0; i < 24; i++) mem[i] = 8'h01 << (i % 8);
        start_and_expect();
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h2002 || mv_indx !== 5'd0) begin
            $display("FAIL first_vert: rdy=%b cmd=%h idx=%0d, expected 1 2002 0", cmd_rdy, cmd, mv_indx); errors++;
        end
        void'(exp_q.pop_front());
        pulse_clr();
        checks++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
            $display("FAIL first_holdv: rdy=%b idx=%0d, expected 0 0", cmd_rdy, mv_indx); errors++;
        end
        pulse_resp();
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== {HOP, 12'hBF1}) begin
            $display("FAIL first_horz: rdy=%b cmd=%h, expected 1 %h", cmd_rdy, cmd, {HOP, 12'hBF1}); errors++;
        end
        void'(exp_q.pop_front());
        pulse_clr();
        checks++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
            $display("FAIL first_holdh: rdy=%b idx=%0d, expected 0 0", cmd_rdy, mv_indx); errors++;
        end
        pulse_resp();
        checks++;
        if (cmd_rdy !== 1'b1 || mv_indx !== 5'd1) begin
            $display("FAIL second_move: rdy=%b idx=%0d, expected 1 1", cmd_rdy, mv_indx); errors++;
        end
        issued = 2;
        serve_cmds(46, 1'b0);
        end_of_tour("single");
    endtask

    task automatic test_busy_tour();
        for (int i = 0; i < 24; i++) mem[i] = 8'h01 << ((i * 3 + 1) % 8);
        start_and_expect();
        serve_cmds(48, 1'b1);
        end_of_tour("busy");
    endtask

    task automatic test_edge_moves();
        for (int i = 0; i < 24; i++) mem[i] = 8'h80 >> (i % 8);
        mem[0] = 8'h00; mem[1] = 8'h84; mem[2] = 8'hFF; mem[3] = 8'h60;
        mem[11] = 8'h00; mem[23] = 8'h84;
        start_and_expect();
        serve_cmds(48, 1'b0);
        end_of_tour("edge");
    endtask

    task automatic test_reset_mid_tour();
        for (int i = 0; i < 24; i++) mem[i] = 8'h01 << ((i * 5) % 8);
        start_and_expect();
        serve_cmds(14, 1'b0);
        checks++;
        if (cmd_rdy !== 1'b1 || mv_indx !== 5'd7) begin
            $display("FAIL move7_vert: rdy=%b idx=%0d, expected 1 7", cmd_rdy, mv_indx); errors++;
        end
        pulse_clr();
        rst_n = 1'b0;
        #1;
        checks++;
        if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd_rdy !== 1'b0) begin
            $display("FAIL mid_reset: idx=%0d resp=%h rdy=%b, expected 0 a5 0", mv_indx, resp, cmd_rdy); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1; cmd_UART = 16'h2ABC; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        #1;
        checks++;
        if (cmd !== 16'h2ABC || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
            $display("FAIL post_reset_uart: cmd=%h rdy=%b clr=%b, expected 2abc 1 1", cmd, cmd_rdy, clr_cmd_rdy_UART); errors++;
        end
        @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 24; i++) mem[i] = 8'h00;
        test_reset();
        test_passthrough();
        if (!abort) test_single_move();
        if (!abort) test_busy_tour();
        if (!abort) test_edge_moves();
        if (!abort) test_reset_mid_tour();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
